param_stack: RTL and testbench

Parametrised hardware LIFO stack. Successor to the fixed 64K-word memory stack and separate stack pointer: storage, pointer and a registered top-of-stack in one block. Adds configurable width and depth, full/empty status, an occupancy count, combined pop+push (replace-top) and sticky overflow/underflow error flags. Sits on the shared tristate data bus next to the word registers, and serves as the CPU call/data stack.

---
 rtl/stack_pkg.sv | 15 +
 rtl/stack_ram.sv | 34 +++
 rtl/param_stack.sv | 135 +++++++++++++
 tb/tb_param_stack.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the parameterised LIFO stack: operation encoding and default sizes.
package stack_pkg;

  localparam int unsigned STACK_WIDTH = 16;
  localparam int unsigned STACK_DEPTH = 16;

  // Operation decoded directly from {push, pop}.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port and one asynchronous read port.
module stack_ram
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           i_clock,
  input  logic           i_we,
  input  logic [AW-1:0]  i_waddr,
  input  logic [0:WIDTH-1] i_wdata,
  input  logic [AW-1:0]  i_raddr,
  output logic [0:WIDTH-1] o_rdata
);

  logic [0:WIDTH-1] r_mem [DEPTH];

  // Write port; contents are not reset.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read; out-of-range addresses (non power-of-two depth) read as zero.
  always_comb begin
    o_rdata = '0;
    if ({1'b0, i_raddr} < (AW + 1)'(DEPTH)) begin
      o_rdata = r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack with registered top-of-stack, occupancy count, full/empty
// status, replace-top operation and sticky overflow/underflow flags. Drives the shared
// bus with the top entry when i_s is asserted.
module param_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  inout  wire  [0:WIDTH-1] bus,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_s,
  input  logic             i_clear_err,
  output logic [0:WIDTH-1] o_top,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [CW-1:0]    r_count;
  logic [0:WIDTH-1] r_top;
  logic             r_overflow;
  logic             r_underflow;

  logic [CW-1:0]    w_count_d;
  logic [0:WIDTH-1] w_top_d;
  logic             w_overflow_d;
  logic             w_underflow_d;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;
  logic [0:WIDTH-1] w_rdata;
  logic             w_empty;
  logic             w_full;
  op_e              w_op;

  assign w_op    = op_e'({i_push, i_pop});
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCount);
  // Entry just below the current top; only meaningful when count >= 2.
  assign w_raddr = AW'(r_count - CW'(2));

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clock (i_clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Next-state decode for count, top-of-stack, memory write and error flags.
  always_comb begin
    w_count_d     = r_count;
    w_top_d       = r_top;
    w_overflow_d  = r_overflow & ~i_clear_err;
    w_underflow_d = r_underflow & ~i_clear_err;
    w_we          = 1'b0;
    w_waddr       = AW'(r_count);
    unique case (w_op)
      OP_NOP: ;
      OP_PUSH: begin
        if (w_full) begin
          w_overflow_d = 1'b1;
        end else begin
          w_we      = 1'b1;
          w_count_d = r_count + CW'(1);
          w_top_d   = bus;
        end
      end
      OP_POP: begin
        if (w_empty) begin
          w_underflow_d = 1'b1;
        end else if (r_count == CW'(1)) begin
          w_count_d = '0;
          w_top_d   = '0;
        end else begin
          w_count_d = r_count - CW'(1);
          w_top_d   = w_rdata;
        end
      end
      OP_REPLACE: begin
        // Overwrite the top in place; on an empty stack this degenerates to a push.
        w_we    = 1'b1;
        w_top_d = bus;
        if (w_empty) begin
          w_count_d = CW'(1);
        end else begin
          w_waddr = AW'(r_count - CW'(1));
        end
      end
      default: ;
    endcase
    // Reset wins over any operation in the same cycle, including the memory write.
    if (i_reset) begin
      w_we = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count     <= '0;
      r_top       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_d;
      r_top       <= w_top_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
    end
  end

  assign bus         = i_s ? r_top : 'z;
  assign o_top       = r_top;
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH=4): directed scenarios followed by random
// operations, all checked against a queue-based model of the stack.
module tb_param_stack;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
  localparam int unsigned C = $clog2(D + 1);

  logic         clk;
  logic         rst;
  logic         push;
  logic         pop;
  logic         s;
  logic         clr;
  logic         tb_en;
  logic [0:W-1] tb_data;
  wire  [0:W-1] bus;
  logic [0:W-1] top;
  logic [C-1:0] count;
  logic         empty;
  logic         full;
  logic         ovf;
  logic         unf;

  assign bus = tb_en ? tb_data : 'z;

  param_stack #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .bus         (bus),
    .i_push      (push),
    .i_pop       (pop),
    .i_s         (s),
    .i_clear_err (clr),
    .o_top       (top),
    .o_count     (count),
    .o_empty     (empty),
    .o_full      (full),
    .o_overflow  (ovf),
    .o_underflow (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model: queue with the last element as the top of stack.
  logic [W-1:0] mq[$];
  logic         m_ovf;
  logic         m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mtop();
    return (mq.size() > 0) ? mq[mq.size() - 1] : '0;
  endfunction

  task automatic check_state();
    check("count", 32'(count), 32'(mq.size()));
    check("top", 32'(top), 32'(mtop()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == D));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("underflow", 32'(unf), 32'(m_unf));
  endtask

  // One clocked operation: drive at negedge, check bus, apply edge, update model, check.
  task automatic do_op(input logic p, input logic q, input logic se, input logic ce,
                       input logic [W-1:0] d);
    logic [W-1:0] eff;
    @(negedge clk);
    push    = p;
    pop     = q;
    s       = se;
    clr     = ce;
    tb_data = d;
    tb_en   = ~se;
    #1;
    if (se) check("bus_drive", 32'(bus), 32'(mtop()));
    else    check("bus_in", 32'(bus), 32'(d));
    eff = se ? mtop() : d;
    @(posedge clk);
    if (ce) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (p && q) begin
      if (mq.size() == 0) mq.push_back(eff);
      else mq[mq.size() - 1] = eff;
    end else if (p) begin
      if (mq.size() == D) m_ovf = 1'b1;
      else mq.push_back(eff);
    end else if (q) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else void'(mq.pop_back());
    end
    #1;
    check_state();
  endtask

  task automatic do_reset(input logic p, input logic q);
    @(negedge clk);
    rst     = 1'b1;
    push    = p;
    pop     = q;
    s       = 1'b0;
    clr     = 1'b0;
    tb_en   = 1'b1;
    tb_data = W'($urandom);
    @(posedge clk);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_state();
    @(negedge clk);
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    s       = 1'b0;
    clr     = 1'b0;
    tb_en   = 1'b0;
    tb_data = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst = 1'b0;

    // Basic push/pop ordering.
    do_op(1, 0, 0, 0, 16'h1111);
    do_op(1, 0, 0, 0, 16'h2222);
    do_op(1, 0, 0, 0, 16'h3333);
    check("tp1_count3", 32'(count), 32'd3);
    check("tp1_top3333", 32'(top), 32'h3333);
    do_op(0, 1, 0, 0, '0);
    check("tp1_top2222", 32'(top), 32'h2222);
    do_op(0, 1, 0, 0, '0);
    do_op(0, 1, 0, 0, '0);
    check("tp1_empty", 32'(empty), 32'd1);

    // Overflow at DEPTH=4.
    for (int i = 0; i < 5; i++) do_op(1, 0, 0, 0, W'(16'h0A00 + i));
    check("tp2_top4th", 32'(top), 32'h0A03);
    check("tp2_ovf", 32'(ovf), 32'd1);
    do_op(0, 1, 0, 0, '0);
    check("tp2_top3rd", 32'(top), 32'h0A02);
    check("tp2_ovf_sticky", 32'(ovf), 32'd1);

    // Underflow and clear priority.
    for (int i = 0; i < 4; i++) do_op(0, 1, 0, 0, '0);
    check("tp3_unf", 32'(unf), 32'd1);
    do_op(0, 0, 0, 1, '0);
    check("tp3_cleared", 32'(unf), 32'd0);
    do_op(0, 1, 0, 1, '0);
    check("tp3_set_wins", 32'(unf), 32'd1);

    // Replace-top, including on an empty stack.
    do_op(1, 0, 0, 1, 16'hAAAA);
    do_op(1, 1, 0, 0, 16'hBBBB);
    check("tp4_top_bbbb", 32'(top), 32'hBBBB);
    do_op(0, 1, 0, 0, '0);
    do_op(1, 1, 0, 0, 16'hCCCC);
    check("tp4_empty_rep", 32'(count), 32'd1);
    do_op(1, 1, 1, 0, 16'h5555);
    check("tp4_self_rep", 32'(top), 32'hCCCC);
    do_op(0, 1, 0, 0, '0);

    // Push with output enable duplicates the top.
    do_op(1, 0, 0, 0, 16'h1234);
    do_op(1, 0, 1, 0, 16'hFFFF);
    check("tp5_dup_count", 32'(count), 32'd2);
    do_op(0, 1, 0, 0, '0);
    check("tp5_dup_below", 32'(top), 32'h1234);

    // Reset beats a simultaneous push.
    for (int i = 0; i < 3; i++) do_op(1, 0, 0, 0, W'($urandom));
    do_reset(1, 0);
    check("tp6_rst_count", 32'(count), 32'd0);

    // Random operations.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset(1'($urandom), 1'($urandom));
      end else begin
        do_op(1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) == 0, W'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
